// File: rtl/traffic_light_monitor.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_monitor
// Brief    : Passive checker for the four controller light buses; flags
//            encoding, conflict, sequence, yellow-timing and starvation errors.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_light_monitor #(
    parameter int YEL_MIN = 3,
    parameter int YEL_MAX = 5,
    parameter int RED_MAX = 60,
    parameter int CW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    light_M1,
    input  logic [2:0]    light_S,
    input  logic [2:0]    light_M2,
    input  logic [2:0]    light_MT,
    input  logic          clr_err,
    output logic          err_pulse,
    output logic [2:0]    err_code,
    output logic [1:0]    err_src,
    output logic [4:0]    err_sticky,
    output logic [CW-1:0] s_cycles
);

    localparam logic [2:0]    c_RED       = 3'b100;
    localparam logic [2:0]    c_YEL       = 3'b010;
    localparam logic [2:0]    c_GRN       = 3'b001;
    localparam logic [CW-1:0] c_DWELL_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] c_YEL_MIN   = CW'(YEL_MIN);
    localparam logic [CW-1:0] c_YEL_LONG  = CW'(YEL_MAX + 1);
    localparam logic [CW-1:0] c_RED_LONG  = CW'(RED_MAX + 1);

    logic [2:0] r_smp [4];
    logic       r_smp_vld;
    logic       r_clr;

    // clr_err travels with the light sample so it lines up with the errors it races
    always_ff @(posedge clk) begin
        if (rst) begin
            r_smp[0]  <= '0;
            r_smp[1]  <= '0;
            r_smp[2]  <= '0;
            r_smp[3]  <= '0;
            r_smp_vld <= 1'b0;
            r_clr     <= 1'b0;
        end else begin
            r_smp[0]  <= light_M1;
            r_smp[1]  <= light_S;
            r_smp[2]  <= light_M2;
            r_smp[3]  <= light_MT;
            r_smp_vld <= 1'b1;
            r_clr     <= clr_err;
        end
    end

    logic [3:0] w_illegal;
    logic [3:0] w_badseq;
    logic [3:0] w_yel;
    logic [3:0] w_starve;
    logic [3:0] w_nonred;
    logic       w_s_done;

    for (genvar gi = 0; gi < 4; gi++) begin : g_light
        logic [2:0]    r_prev;
        logic [CW-1:0] r_dwell;
        logic          r_armed;
        logic [2:0]    w_v;
        logic          w_legal;
        logic          w_chg;
        logic          w_step_ok;
        logic          w_yel_short;
        logic [CW-1:0] w_dwell_nx;

        assign w_v       = r_smp[gi];
        assign w_legal   = (w_v == c_RED) || (w_v == c_YEL) || (w_v == c_GRN);
        assign w_chg     = (w_v != r_prev);
        assign w_step_ok = ((r_prev == c_GRN) && (w_v == c_YEL)) ||
                           ((r_prev == c_YEL) && (w_v == c_RED)) ||
                           ((r_prev == c_RED) && (w_v == c_GRN));
        // r_dwell still holds the yellow dwell on the sample that leaves yellow
        assign w_yel_short = r_smp_vld && r_armed && (r_prev == c_YEL) && w_chg &&
                             (r_dwell < c_YEL_MIN);

        always_comb begin
            if (!w_legal || w_chg)
                w_dwell_nx = CW'(1);
            else if (r_dwell == c_DWELL_MAX)
                w_dwell_nx = r_dwell;
            else
                w_dwell_nx = r_dwell + CW'(1);
        end

        assign w_illegal[gi] = r_smp_vld && !w_legal;
        assign w_badseq[gi]  = r_smp_vld && r_armed && w_legal && w_chg && !w_step_ok;
        assign w_yel[gi]     = w_yel_short ||
                               (r_smp_vld && (w_v == c_YEL) && (w_dwell_nx == c_YEL_LONG));
        assign w_starve[gi]  = r_smp_vld && (w_v == c_RED) && (w_dwell_nx == c_RED_LONG);
        assign w_nonred[gi]  = r_smp_vld && (w_v[1] || w_v[0]);

        if (gi == 1) begin : g_s_count
            assign w_s_done = r_smp_vld && r_armed && (r_prev == c_YEL) &&
                              (w_v == c_RED) && !w_yel_short;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_prev  <= '0;
                r_dwell <= '0;
                r_armed <= 1'b0;
            end else if (r_smp_vld) begin
                r_prev  <= w_v;
                r_dwell <= w_dwell_nx;
                r_armed <= w_legal;
            end
        end
    end

    logic       w_conf_s;
    logic       w_conf_m;
    logic [4:0] w_cls;
    logic [2:0] w_code;
    logic [1:0] w_src;

    assign w_conf_s = w_nonred[1] && (w_nonred[0] || w_nonred[2] || w_nonred[3]);
    assign w_conf_m = w_nonred[2] && w_nonred[3];
    assign w_cls    = {|w_starve, |w_yel, |w_badseq, w_conf_s || w_conf_m, |w_illegal};

    function automatic logic [1:0] f_lowest(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else if (v[3]) return 2'd3;
        else           return 2'd0;
    endfunction

    always_comb begin
        w_code = 3'd0;
        w_src  = 2'd0;
        if (w_cls[0]) begin
            w_code = 3'd1;
            w_src  = f_lowest(w_illegal);
        end else if (w_cls[1]) begin
            w_code = 3'd2;
            w_src  = w_conf_s ? 2'd1 : 2'd2;
        end else if (w_cls[2]) begin
            w_code = 3'd3;
            w_src  = f_lowest(w_badseq);
        end else if (w_cls[3]) begin
            w_code = 3'd4;
            w_src  = f_lowest(w_yel);
        end else if (w_cls[4]) begin
            w_code = 3'd5;
            w_src  = f_lowest(w_starve);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_pulse  <= 1'b0;
            err_code   <= 3'd0;
            err_src    <= 2'd0;
            err_sticky <= 5'd0;
            s_cycles   <= '0;
        end else begin
            err_pulse  <= |w_cls;
            if (|w_cls) begin
                err_code <= w_code;
                err_src  <= w_src;
            end
            err_sticky <= r_clr ? w_cls : (err_sticky | w_cls);
            if (w_s_done)
                s_cycles <= s_cycles + CW'(1);
        end
    end

endmodule
`default_nettype wire
